// File: rtl/bcd_pkg.sv
// Shared types and helpers for the digit-serial BCD adder/subtractor.
package bcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PASS1 = 2'd1,
    S_PASS2 = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef logic [3:0] digit_t;

  localparam digit_t BCD_NINE = 4'd9;
  localparam digit_t BCD_TEN  = 4'd10;

  function automatic digit_t nines_comp(input digit_t d);
    return BCD_NINE - d;
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Single-digit BCD adder with decimal correction; shared by both passes.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  digit_t i_a,
  input  digit_t i_b,
  input  logic   i_cin,
  output digit_t o_sum,
  output logic   o_cout
);

  logic [4:0] w_s;

  always_comb begin
    w_s    = 5'(i_a) + 5'(i_b) + 5'(i_cin);
    o_sum  = w_s[3:0];
    o_cout = 1'b0;
    if (w_s > 5'(BCD_NINE)) begin
      o_sum  = 4'(w_s - 5'(BCD_TEN));
      o_cout = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_addsub_seq.sv
// Digit-serial N-digit BCD add/subtract, sign-magnitude result.
// Optional input-digit legality check enabled by defining BCD_DIGIT_CHECK_EN.
module bcd_addsub_seq
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                op,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] result,
  output logic                neg,
  output logic                ovf,
  output logic                err
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t          r_state;
  logic [W-1:0]    r_a, r_b, r_acc, r_result;
  logic [IDXW-1:0] r_idx;
  logic            r_op, r_carry, r_eac, r_nz;
  logic            r_neg, r_ovf, r_in_ready, r_out_valid;

  digit_t          w_da, w_db, w_sum;
  logic            w_cin, w_cout, w_last;
  logic [W-1:0]    w_acc_next;

  // Operand select: pass 1 adds a + b (or 9's complement of b); pass 2
  // either ripples the end-around carry or re-complements each digit.
  always_comb begin
    w_da  = r_a[3:0];
    w_db  = r_op ? nines_comp(r_b[3:0]) : r_b[3:0];
    w_cin = r_carry;
    if (r_state == S_PASS2) begin
      w_da  = r_eac ? r_acc[3:0] : nines_comp(r_acc[3:0]);
      w_db  = '0;
      w_cin = r_eac & r_carry;
    end
  end

  bcd_digit_adder u_digit_adder (
    .i_a    (w_da),
    .i_b    (w_db),
    .i_cin  (w_cin),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Accumulator shifts right one digit per cycle; new digit enters at the top.
  assign w_acc_next = (r_acc >> 4) | (W'(w_sum) << (W - 4));
  assign w_last     = (r_idx == IDXW'(DIGITS - 1));

`ifdef BCD_DIGIT_CHECK_EN
  logic w_bad;
  logic r_err;

  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if ((a[4*i +: 4] > BCD_NINE) || (b[4*i +: 4] > BCD_NINE)) w_bad = 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_result    <= '0;
      r_idx       <= '0;
      r_op        <= 1'b0;
      r_carry     <= 1'b0;
      r_eac       <= 1'b0;
      r_nz        <= 1'b0;
      r_neg       <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
      r_err       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_op       <= op;
            r_carry    <= 1'b0;
            r_idx      <= '0;
            r_acc      <= '0;
            r_nz       <= 1'b0;
            r_neg      <= 1'b0;
            r_ovf      <= 1'b0;
            r_in_ready <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
            r_err      <= w_bad;
            if (w_bad) begin
              r_result    <= '0;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_state     <= S_PASS1;
            end
`else
            r_state    <= S_PASS1;
`endif
          end
        end
        S_PASS1: begin
          r_acc   <= w_acc_next;
          r_a     <= r_a >> 4;
          r_b     <= r_b >> 4;
          r_carry <= w_cout;
          r_idx   <= r_idx + IDXW'(1);
          if (w_last) begin
            r_idx <= '0;
            if (r_op) begin
              r_eac   <= w_cout;
              r_state <= S_PASS2;
            end else begin
              r_result    <= w_acc_next;
              r_ovf       <= w_cout;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_PASS2: begin
          r_acc   <= w_acc_next;
          r_carry <= w_cout;
          r_idx   <= r_idx + IDXW'(1);
          if (w_sum != '0) r_nz <= 1'b1;
          if (w_last) begin
            r_idx       <= '0;
            r_result    <= w_acc_next;
            r_neg       <= ~r_eac & (r_nz | (w_sum != '0));
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign neg       = r_neg;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_bcd_addsub_seq.sv
// Directed self-checking bench for bcd_addsub_seq (DIGITS=4).
module tb_bcd_addsub_seq;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         op;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         neg, ovf, err;

  int n_checks = 0;
  int n_errors = 0;
  int n_lat;

  always #5 clk = ~clk;

  bcd_addsub_seq #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .neg       (neg),
    .ovf       (ovf),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Present one operation to an idle DUT; returns just after the accept edge.
  task automatic issue(input logic iop, input logic [W-1:0] ia, input logic [W-1:0] ib);
    @(negedge clk);
    op = iop; a = ia; b = ib; in_valid = 1'b1; out_ready = 1'b0;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = '0; b = '0;
    n_lat = 1;
    chk("in_ready_busy", 32'(in_ready), 32'd0);
  endtask

  // Wait (bounded) for out_valid, then check fields, latency and hold behaviour.
  task automatic wait_done(input string tag, input logic [W-1:0] exp_res,
                           input logic exp_neg, input logic exp_ovf, input int exp_lat);
    while (!out_valid && n_lat < 40) begin
      @(posedge clk); #1;
      n_lat++;
    end
    chk({tag, "_latency"}, 32'(n_lat), 32'(exp_lat));
    chk({tag, "_result"},  32'(result), 32'(exp_res));
    chk({tag, "_neg"},     32'(neg), 32'(exp_neg));
    chk({tag, "_ovf"},     32'(ovf), 32'(exp_ovf));
    chk({tag, "_err"},     32'(err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_hold_valid"},  32'(out_valid), 32'd1);
    chk({tag, "_hold_result"}, 32'(result), 32'(exp_res));
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result",    32'(result), 32'd0);
    chk("rst_neg_ovf",   {30'd0, neg, ovf}, 32'd0);
    chk("rst_err",       32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(1'b0, 16'h1234, 16'h5678); wait_done("add_1234_5678", 16'h6912, 1'b0, 1'b0, 5); release_out("r1");
    issue(1'b0, 16'h9999, 16'h0001); wait_done("add_9999_0001", 16'h0000, 1'b0, 1'b1, 5); release_out("r2");
    issue(1'b0, 16'h5000, 16'h5000); wait_done("add_5000_5000", 16'h0000, 1'b0, 1'b1, 5); release_out("r3");
    issue(1'b1, 16'h0012, 16'h0005); wait_done("sub_0012_0005", 16'h0007, 1'b0, 1'b0, 9); release_out("r4");
    issue(1'b1, 16'h0003, 16'h0005); wait_done("sub_0003_0005", 16'h0002, 1'b1, 1'b0, 9); release_out("r5");
    issue(1'b1, 16'h0005, 16'h0005); wait_done("sub_0005_0005", 16'h0000, 1'b0, 1'b0, 9); release_out("r6");
    issue(1'b1, 16'h0000, 16'h9999); wait_done("sub_0000_9999", 16'h9999, 1'b1, 1'b0, 9);

    // Handoff with new operands already presented: only the handoff happens.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; op = 1'b0; a = 16'h0457; b = 16'h0045;
    @(posedge clk); #1;
    chk("b2b_handoff_valid", 32'(out_valid), 32'd0);
    chk("b2b_not_accepted",  32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("b2b_accepted", 32'(in_ready), 32'd0);
    in_valid = 1'b0; out_ready = 1'b0;
    n_lat = 1;
    wait_done("add_0457_0045", 16'h0502, 1'b0, 1'b0, 5); release_out("r7");

    // Reset during the second pass of a subtract.
    issue(1'b1, 16'h0012, 16'h0005);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready",  32'(in_ready), 32'd1);
    chk("midrst_result",    32'(result), 32'd0);
    chk("midrst_neg_ovf",   {30'd0, neg, ovf}, 32'd0);
    @(posedge clk); #1;
    chk("midrst_still_idle", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b1, 16'h0100, 16'h0001); wait_done("sub_0100_0001", 16'h0099, 1'b0, 1'b0, 9); release_out("r8");

`ifdef BCD_DIGIT_CHECK_EN
    issue(1'b0, 16'h00A1, 16'h0000);
    while (!out_valid && n_lat < 40) begin
      @(posedge clk); #1;
      n_lat++;
    end
    chk("bad_digit_valid",  32'(out_valid), 32'd1);
    chk("bad_digit_err",    32'(err), 32'd1);
    chk("bad_digit_result", 32'(result), 32'd0);
    chk("bad_digit_neg_ovf", {30'd0, neg, ovf}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("bad_digit_hold", 32'(out_valid), 32'd1);
    chk("bad_digit_hold_err", 32'(err), 32'd1);
    release_out("r9");
`else
    issue(1'b0, 16'h00A1, 16'h0000);
    while (!out_valid && n_lat < 40) begin
      @(posedge clk); #1;
      n_lat++;
    end
    chk("bad_digit_latency", 32'(n_lat), 32'd5);
    chk("bad_digit_err_tied", 32'(err), 32'd0);
    release_out("r9");
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
